// File: rtl/seg_scan_decoder.sv
// Reads back a multiplexed common-anode 7-segment bus (active-low seg, one-hot sel) and rebuilds
// per-digit BCD, decimal point and validity. Optional macro SEG_HEX_EN adds A..F recognition.
module seg_scan_decoder #(
    parameter int NUM_DIG    = 4,
    parameter int STABLE_CYC = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             seg,
    input  logic [NUM_DIG-1:0]     sel,
    output logic [4*NUM_DIG-1:0]   bcd,
    output logic [NUM_DIG-1:0]     dp,
    output logic [NUM_DIG-1:0]     dig_valid,
    output logic                   frame_done,
    output logic                   err
);

    localparam logic [3:0] CNT_MAX = 4'(STABLE_CYC);
    localparam logic [3:0] CNT_PRE = 4'(STABLE_CYC - 1);
    localparam logic [NUM_DIG-1:0] ALL_SEEN = {NUM_DIG{1'b1}};

    logic [7:0]         seg_q;
    logic [NUM_DIG-1:0] sel_q;
    logic [3:0]         cnt;
    logic [3:0]         cnt_nxt;
    logic [NUM_DIG-1:0] seen;
    logic [NUM_DIG-1:0] seen_nxt;
    logic               onehot;
    logic               same;
    logic               capture;
    logic               pat_ok;
    logic               pat_blank;
    logic [3:0]         pat_val;

    // Dwell counter: counts consecutive identical one-hot samples, saturating at CNT_MAX so a
    // long dwell yields exactly one capture on the CNT_PRE -> CNT_MAX transition.
    always_comb begin
        onehot  = $onehot(sel);
        same    = (seg == seg_q) && (sel == sel_q);
        cnt_nxt = 4'd1;
        if (!onehot)
            cnt_nxt = 4'd0;
        else if (same)
            cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 4'd1;
        capture  = onehot && same && (cnt == CNT_PRE);
        seen_nxt = seen | sel;
    end

    always_comb begin
        pat_ok    = 1'b1;
        pat_blank = 1'b0;
        pat_val   = 4'd0;
        case (seg[6:0])
            7'h40: pat_val = 4'd0;
            7'h79: pat_val = 4'd1;
            7'h24: pat_val = 4'd2;
            7'h30: pat_val = 4'd3;
            7'h19: pat_val = 4'd4;
            7'h12: pat_val = 4'd5;
            7'h02: pat_val = 4'd6;
            7'h78: pat_val = 4'd7;
            7'h00: pat_val = 4'd8;
            7'h10: pat_val = 4'd9;
`ifdef SEG_HEX_EN
            7'h08: pat_val = 4'hA;
            7'h03: pat_val = 4'hB;
            7'h46: pat_val = 4'hC;
            7'h21: pat_val = 4'hD;
            7'h06: pat_val = 4'hE;
            7'h0E: pat_val = 4'hF;
`endif
            7'h7F: begin
                pat_ok    = 1'b0;
                pat_blank = 1'b1;
            end
            default: pat_ok = 1'b0;
        endcase
    end

    // frame_done and err are single-cycle pulses, registered on the capture edge; there is no
    // back-pressure, so a consumer must sample them on every clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q      <= 8'hFF;
            sel_q      <= '0;
            cnt        <= 4'd0;
            seen       <= '0;
            bcd        <= '0;
            dp         <= '0;
            dig_valid  <= '0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            seg_q      <= seg;
            sel_q      <= sel;
            cnt        <= cnt_nxt;
            frame_done <= 1'b0;
            err        <= 1'b0;
            if (capture) begin
                for (int i = 0; i < NUM_DIG; i++) begin
                    if (sel[i]) begin
                        dp[i]        <= ~seg[7];
                        dig_valid[i] <= pat_ok;
                        if (pat_ok || pat_blank)
                            bcd[4*i +: 4] <= pat_val;
                    end
                end
                err <= !pat_ok && !pat_blank;
                if (seen_nxt == ALL_SEEN) begin
                    frame_done <= 1'b1;
                    seen       <= '0;
                end else begin
                    seen <= seen_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: a driver feeds directed and random scan traffic, a
// sample-history reference model predicts outputs, and a monitor compares every cycle.
module tb_seg_scan_decoder;

    localparam int ND = 4;
    localparam int N  = 3;
    localparam int W  = 6*ND + 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        seg = 8'h99;
    logic [ND-1:0]     sel = 4'b0001;
    logic [4*ND-1:0]   bcd;
    logic [ND-1:0]     dp;
    logic [ND-1:0]     dig_valid;
    logic              frame_done;
    logic              err;

    seg_scan_decoder #(.NUM_DIG(ND), .STABLE_CYC(N)) dut (
        .clk(clk), .rst(rst), .seg(seg), .sel(sel), .bcd(bcd), .dp(dp),
        .dig_valid(dig_valid), .frame_done(frame_done), .err(err)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    logic [6:0] dec_pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [6:0] hex_pat [6]  = '{7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic [3:0]    m_bcd [ND];
    logic [ND-1:0] m_dp, m_valid, m_seen;
    logic [7+ND:0] hist[$];

    function automatic void ref_decode(input logic [6:0] p, output logic known,
                                       output logic blank, output logic [3:0] v);
        known = 1'b0;
        blank = (p == 7'h7F);
        v     = 4'd0;
        for (int k = 0; k < 10; k++)
            if (dec_pat[k] == p) begin known = 1'b1; v = 4'(k); end
`ifdef SEG_HEX_EN
        for (int k = 0; k < 6; k++)
            if (hex_pat[k] == p) begin known = 1'b1; v = 4'(10 + k); end
`endif
    endfunction

    // Capture happens when the newest N samples are identical with a one-hot select and the
    // sample just before them (or the reset state) differs.
    function automatic logic [W-1:0] model_step(input logic r, input logic [7:0] s, input logic [ND-1:0] se);
        logic fd, er, cap, known, blank;
        logic [3:0] v;
        logic [7+ND:0] cur;
        logic [4*ND-1:0] bv;
        int n, d;
        fd = 1'b0;
        er = 1'b0;
        if (r) begin
            for (int i = 0; i < ND; i++) m_bcd[i] = 4'd0;
            m_dp = '0; m_valid = '0; m_seen = '0;
            hist.delete();
        end else begin
            cur = {s, se};
            hist.push_back(cur);
            if (hist.size() > N + 1) void'(hist.pop_front());
            n = hist.size();
            cap = $onehot(se) && (n >= N);
            if (cap) begin
                for (int k = n - N; k < n; k++) if (hist[k] != cur) cap = 1'b0;
                if (n == N + 1 && hist[0] == cur) cap = 1'b0;
            end
            if (cap) begin
                d = 0;
                for (int i = 0; i < ND; i++) if (se[i]) d = i;
                ref_decode(s[6:0], known, blank, v);
                m_dp[d]    = ~s[7];
                m_valid[d] = known;
                if (known || blank) m_bcd[d] = v;
                er = !known && !blank;
                m_seen[d] = 1'b1;
                if (&m_seen) begin fd = 1'b1; m_seen = '0; end
            end
        end
        for (int i = 0; i < ND; i++) bv[4*i +: 4] = m_bcd[i];
        return {bv, m_dp, m_valid, fd, er};
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic r, input logic [7:0] s, input logic [ND-1:0] se, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            #1;
            rst = r; seg = s; sel = se;
            exp_q.push_back(model_step(r, s, se));
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] act, e;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {bcd, dp, dig_valid, frame_done, err};
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL outputs t=%0t actual bcd=%h dp=%b valid=%b fd=%b err=%b required bcd=%h dp=%b valid=%b fd=%b err=%b",
                         $time, act[W-1 -: 4*ND], act[2*ND+1 -: ND], act[ND+1 -: ND], act[1], act[0],
                         e[W-1 -: 4*ND], e[2*ND+1 -: ND], e[ND+1 -: ND], e[1], e[0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] pats [4];
        logic [7:0] s, prev_s;
        logic [ND-1:0] se;
        int pick;
        pats = '{8'hF9, 8'hA4, 8'h30, 8'h92};

        // reset with a digit already presented, then release
        drive(1'b1, 8'h99, 4'b0001, 2);
        drive(1'b0, 8'h99, 4'b0001, 4);
        // full scan 0..3
        for (int i = 0; i < ND; i++) drive(1'b0, pats[i], 4'(1 << i), 4);
        // glitch rejection on digit 1
        drive(1'b0, 8'hC0, 4'b0010, 4);
        drive(1'b0, 8'h80, 4'b0010, 2);
        drive(1'b0, 8'hC0, 4'b0010, 4);
        // illegal selects
        drive(1'b0, 8'hA4, 4'b0110, 10);
        drive(1'b0, 8'hA4, 4'b0000, 10);
        // blank and unrecognised patterns
        drive(1'b0, 8'hFF, 4'b0001, 4);
        drive(1'b0, 8'h88, 4'b0010, 4);
        // long dwell, then reset mid-dwell
        drive(1'b0, 8'h82, 4'b0100, 50);
        drive(1'b0, 8'hC0, 4'b1000, 2);
        drive(1'b1, 8'hC0, 4'b1000, 1);
        drive(1'b0, 8'hC0, 4'b1000, 4);

        // randomized scan traffic
        prev_s = 8'hC0;
        for (int t = 0; t < 400; t++) begin
            pick = $urandom_range(0, 9);
            if (pick <= 5)      s = {1'($urandom_range(0, 1)), dec_pat[$urandom_range(0, 9)]};
            else if (pick == 6) s = {1'($urandom_range(0, 1)), 7'h7F};
            else if (pick == 7) s = {1'($urandom_range(0, 1)), hex_pat[$urandom_range(0, 5)]};
            else if (pick == 8) s = 8'($urandom);
            else                s = prev_s;
            prev_s = s;
            if ($urandom_range(0, 99) < 85) se = 4'(1 << $urandom_range(0, ND - 1));
            else                            se = 4'($urandom);
            if ($urandom_range(0, 59) == 0) drive(1'b1, s, se, $urandom_range(1, 2));
            drive(1'b0, s, se, $urandom_range(1, 7));
        end

        @(negedge clk);
        @(negedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d pending required=0", exp_q.size());
        end
        checks++;
        if (checks < 12) begin
            errors++;
            $display("FAIL check_count actual=%0d required>=12", checks);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Reads back a multiplexed common-anode 7-segment display bus (active-low segment byte plus one-hot digit select) and reconstructs the per-digit BCD value and decimal point. It sits on the watch's display-drive nets as a monitor, closing the loop on the BCD-to-segment encoders for self-test and readback. Each digit is accepted only after its segment and select lines have been stable for a programmable number of clocks. A pulse marks each completed scan frame.

## Interface
- NUM_DIG, default 4: number of multiplexed digits.
- STABLE_CYC, default 3, range 2..15: consecutive identical samples required before a digit is captured.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- seg  in  8  segment byte, active-low; bit7 = dp, bits6..0 = g..a (0xC0 shows "0").
- sel  in  NUM_DIG  digit select, active-high one-hot; bit i drives digit i.
- bcd  out  4*NUM_DIG  decoded values; digit i at bits [4i+3:4i].
- dp  out  NUM_DIG  decimal point state per digit, 1 = lit.
- dig_valid  out  NUM_DIG  1 = last capture of digit i was a recognised pattern.
- frame_done  out  1  one-cycle pulse when every digit has been captured since the previous pulse.
- err  out  1  one-cycle pulse when a capture finds an unrecognised, non-blank pattern.

## Operation
- Every clock, seg and sel are registered into seg_q/sel_q. A stability counter cnt (4 bits) compares new samples with the held ones:
  - If sel is not exactly one-hot (zero or multiple bits set), cnt = 0 and no capture occurs.
  - Else, if the sample equals the previous sample, cnt increments and saturates at STABLE_CYC.
  - Else, cnt = 1.
- Capture happens on the edge where cnt goes from STABLE_CYC-1 to STABLE_CYC. This gives exactly one capture per dwell.
- Decoding of the capture uses seg[6:0]:
  - 0x40→0, 0x79→1, 0x24→2, 0x30→3, 0x19→4, 0x12→5, 0x02→6, 0x78→7, 0x00→8, 0x10→9. These set dig_valid[i]=1.
  - 0x7F (blank): bcd[i] = 0, dig_valid[i] = 0, no err.
  - Any other pattern: bcd[i] unchanged, dig_valid[i] = 0, err pulse.
  - dp[i] = ~seg[7] on every capture.
- Frame tracking uses a seen mask of NUM_DIG bits. A capture sets bit i.
  - If the mask becomes all ones on a capture, frame_done pulses on that same edge and the mask clears to 0.
  - Captures of an already-seen digit do not pulse frame_done.
- Digits are not required to be scanned in any order. Digit values persist until recaptured.

## Timing
- Reset values: bcd = 0, dp = 0, dig_valid = 0, frame_done = 0, err = 0, cnt = 0, seen = 0, seg_q = 0xFF, sel_q = 0.
- Latency: if new seg/sel are first present before edge E1, the outputs update at edge E(STABLE_CYC). This is STABLE_CYC clocks after first presentation.
- A glitch of fewer than STABLE_CYC cycles is never captured. After the glitch, the original value must again be held for STABLE_CYC samples, and is then recaptured.
- When rst is asserted mid-dwell, all state clears on that edge. A held input needs a full STABLE_CYC samples after rst deasserts before it is captured.
- frame_done and err may pulse on the same edge.

## Configuration
- SEG_HEX_EN defined: the decoder additionally accepts 0x08→A, 0x03→B, 0x46→C, 0x21→D, 0x06→E, 0x0E→F, each with dig_valid=1.
- SEG_HEX_EN undefined: those six patterns are unrecognised and produce err with dig_valid=0.

## Test plan
- Reset behaviour: hold rst 2 cycles with seg=0x99, sel=0001 → all outputs 0. Then release; 3 clocks later bcd[3:0]=4, dig_valid[0]=1.
- Full scan of digits 0..3, patterns 0xF9, 0xA4, 0x30, 0x92, 4 cycles each → bcd=0x5321 (dp from 0x30 lit on digit 2). frame_done pulses once, on the digit-3 capture edge.
- Glitch rejection: with sel=0010 and seg=0xC0 stable, insert seg=0x80 for 2 cycles → bcd[7:4] stays 0. A single capture of 0 follows once 0xC0 has been re-held for 3 cycles.
- Illegal select: sel=0110 or 0000 held 10 cycles → no capture and no pulses.
- Invalid and blank patterns:
  - seg=0xFF → dig_valid low, no err.
  - seg=0x88 → err pulse and dig_valid low; with SEG_HEX_EN, bcd nibble = 0xA, valid, no err.
- Dwell count: hold the same digit for 50 cycles → exactly one capture; seen updates once and no second frame_done.
